// File: rtl/pe_stream_feeder_if.sv
// Bundle between one pe_stream_feeder and its two neighbours: the local word buffer
// (read side) and the PE load port (stream side).
//   rd_en       feeder -> buffer  read strobe
//   rd_addr     feeder -> buffer  read address
//   rd_data     buffer -> feeder  read data, valid the cycle after rd_en
//   start_load  feeder -> PE      1-cycle start_feature_load / start_weight_load pulse
//   data_out    feeder -> PE      word (feature_in / weight_in)
//   data_en     feeder -> PE      word transferred on this edge
//   fifo_full   PE -> feeder      PE input FIFO full (back-pressure)
// master: feeder side; slave: buffer + PE side.
interface pe_stream_feeder_if #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned AddrWidth = 8
);
  logic                 rd_en;
  logic [AddrWidth-1:0] rd_addr;
  logic [DataWidth-1:0] rd_data;
  logic                 start_load;
  logic [DataWidth-1:0] data_out;
  logic                 data_en;
  logic                 fifo_full;

  modport master (
    output rd_en, rd_addr, start_load, data_out, data_en,
    input  rd_data, fifo_full
  );

  modport slave (
    input  rd_en, rd_addr, start_load, data_out, data_en,
    output rd_data, fifo_full
  );
endinterface

// File: rtl/pe_stream_feeder.sv
// Upstream feeder for one PE load port. On an accepted start it reads `length` words from the
// local buffer starting at `base_addr` (address wraps mod 2^AddrWidth), parks them in a 2-entry
// skid FIFO and hands them to the PE one per cycle whenever the PE FIFO is not full.
// Ports:
//   clk_i        clock
//   rst_ni       synchronous reset, active low
//   start_i      1-cycle request, sampled only when idle
//   base_addr_i  first buffer address, latched on accepted start
//   length_i     word count (0 allowed), latched on accepted start
//   busy_o       high from accepted start until done
//   done_o       1-cycle pulse, transfer complete
//   stall_cnt_o  (PE_FEED_STALL_CNT_EN only) cycles a ready word was held back by fifo_full
//   feed         buffer read bus + PE stream port (pe_stream_feeder_if.master)
// Optional feature: define PE_FEED_STALL_CNT_EN to add the stall_cnt_o counter.
module pe_stream_feeder #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned LenWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [LenWidth-1:0]  length_i,
  output logic                 busy_o,
  output logic                 done_o,
`ifdef PE_FEED_STALL_CNT_EN
  output logic [15:0]          stall_cnt_o,
`endif
  pe_stream_feeder_if.master   feed
);

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDone} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic [LenWidth-1:0]  issued_q, issued_d;
  logic [LenWidth-1:0]  sent_q, sent_d;
  logic                 inflight_q, inflight_d;
  logic [DataWidth-1:0] skid_q [2];
  logic [DataWidth-1:0] skid_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           cnt_q, cnt_d;

  logic       active;
  logic       pop;
  logic       rd_en;
  logic       last;
  logic       accept;
  logic       done;
  logic [2:0] occ;

  // Read/pop qualifiers
  always_comb begin
    active = (state_q == StLoad) || (state_q == StStream);
    pop    = (cnt_q != 2'd0) && !feed.fifo_full;
    // Skid occupancy after this cycle's pop plus the word still coming back from the buffer.
    occ    = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, inflight_q};
    rd_en  = active && (issued_q < len_q) && (occ < 3'd2);
    last   = (sent_q == (len_q - LenWidth'(1)));
  end

  // FSM next state. done is raised in the cycle that hands over the final word, so a normal
  // transfer returns straight to idle; StDone only serves zero-length requests.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = (length_i == '0) ? StDone : StLoad;
        end
      end
      StLoad:   state_d = StStream;
      StStream: begin
        if (pop && last) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next state
  always_comb begin
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    sent_d     = sent_q;
    inflight_d = rd_en;
    skid_d     = skid_q;
    wr_ptr_d   = wr_ptr_q ^ inflight_q;
    rd_ptr_d   = rd_ptr_q ^ pop;
    cnt_d      = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    if (inflight_q) begin
      skid_d[wr_ptr_q] = feed.rd_data;
    end
    if (accept) begin
      base_d   = base_addr_i;
      len_d    = length_i;
      issued_d = '0;
      sent_d   = '0;
    end else begin
      if (rd_en) issued_d = issued_q + LenWidth'(1);
      if (pop)   sent_d   = sent_q + LenWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      inflight_q <= inflight_d;
      skid_q     <= skid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef PE_FEED_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (accept) begin
      stall_d = '0;
    end else if ((cnt_q != 2'd0) && feed.fifo_full && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

  assign feed.rd_en      = rd_en;
  assign feed.rd_addr    = base_q + AddrWidth'(issued_q);
  assign feed.start_load = (state_q == StLoad);
  assign feed.data_out   = skid_q[rd_ptr_q];
  assign feed.data_en    = pop;
  assign busy_o          = active && !done;
  assign done_o          = done;

endmodule
